// File: rtl/hazard_ctrl_pkg.sv
// Shared types, opcode constants and decode helpers for the hazard controller slice.
package pipe_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned OP_W  = 6;
    localparam int unsigned CNT_W = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd1;
    localparam logic [OP_W-1:0] OP_LUI   = 6'd3;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'd4;
    localparam logic [OP_W-1:0] OP_ORI   = 6'd5;
    localparam logic [OP_W-1:0] OP_XORI  = 6'd6;
    localparam logic [OP_W-1:0] OP_LW    = 6'd16;
    localparam logic [OP_W-1:0] OP_LH    = 6'd18;
    localparam logic [OP_W-1:0] OP_LB    = 6'd20;
    localparam logic [OP_W-1:0] OP_SW    = 6'd24;
    localparam logic [OP_W-1:0] OP_SH    = 6'd26;
    localparam logic [OP_W-1:0] OP_SB    = 6'd28;
    localparam logic [OP_W-1:0] OP_JAL   = 6'd41;

    localparam logic [REG_W-1:0] LINK_REG = 5'd31;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FREEZE = 2'd2
    } hz_state_t;

    // Tag held for the instruction in EX (ID/EX register).
    typedef struct packed {
        logic             valid;
        logic             we;
        logic [REG_W-1:0] wreg;
        logic             is_load;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [OP_W-1:0]  op;
    } idex_tag_t;

    // Tag held for the instructions in MEM and WB.
    typedef struct packed {
        logic             we;
        logic [REG_W-1:0] wreg;
        logic             is_load;
    } stage_tag_t;

    // Destination register of an opcode; 0 means no architectural write.
    function automatic logic [REG_W-1:0] dest_of(input logic [OP_W-1:0]  op,
                                                 input logic [REG_W-1:0] rt,
                                                 input logic [REG_W-1:0] rd);
        logic [REG_W-1:0] d;
        d = '0;
        case (op)
            OP_RTYPE:                                     d = rd;
            OP_ADDI, OP_LUI, OP_ANDI, OP_ORI, OP_XORI,
            OP_LW, OP_LH, OP_LB:                          d = rt;
            OP_JAL:                                       d = LINK_REG;
            default:                                      d = '0;
        endcase
        return d;
    endfunction

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LB);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle.
//  master: pipeline side, drives ID contents, branch outcome and memory ready.
//  slave : hazard_ctrl, returns stall/flush controls and EX operand forward selects.
interface hazard_ctrl_if;
    import pipe_pkg::*;

    logic                id_valid;
    logic [OP_W-1:0]     id_op;
    logic [REG_W-1:0]    id_rs;
    logic [REG_W-1:0]    id_rt;
    logic [REG_W-1:0]    id_rd;
    logic                br_taken;
    logic                mem_ready;
    logic                stall_if;
    logic                flush_if;
    logic                flush_id;
    fwd_sel_t            fwd_s;
    fwd_sel_t            fwd_t;

    modport master (
        output id_valid, id_op, id_rs, id_rt, id_rd, br_taken, mem_ready,
        input  stall_if, flush_if, flush_id, fwd_s, fwd_t
    );

    modport slave (
        input  id_valid, id_op, id_rs, id_rt, id_rd, br_taken, mem_ready,
        output stall_if, flush_if, flush_id, fwd_s, fwd_t
    );
endinterface

// File: rtl/hazard_ctrl_dest_tracker.sv
// Three-stage shadow of the ID/EX, EX/MEM and MEM/WB destination tags.
//  clk, rst : clock, synchronous active-high reset
//  hold     : freeze every stage (data memory not ready)
//  bubble   : load an empty tag into ID/EX instead of id_tag
//  id_tag   : decoded tag of the instruction currently in ID
//  idex, exmem, memwb : registered stage tags
module dest_tracker
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       bubble,
    input  idex_tag_t  id_tag,
    output idex_tag_t  idex,
    output stage_tag_t exmem,
    output stage_tag_t memwb
);

    // Tag shift register; a bubble is an all-zero tag (valid=0, we=0, rs=rt=0).
    always_ff @(posedge clk) begin
        if (rst) begin
            idex  <= '0;
            exmem <= '0;
            memwb <= '0;
        end else if (!hold) begin
            idex  <= bubble ? '0 : id_tag;
            exmem <= '{we: idex.we, wreg: idex.wreg, is_load: idex.is_load};
            memwb <= exmem;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard / forwarding controller for the 5-stage core.
//  clk, rst : clock, synchronous active-high reset
//  hz       : slave side of hazard_ctrl_if (ID contents, br_taken, mem_ready in;
//             stall_if, flush_if, flush_id, fwd_s, fwd_t out)
//  LOAD_LAT : load-use bubbles inserted, 1 or 2
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave hz
);

    hz_state_t          state, state_n, saved, saved_n, eff_state;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               hold_c, bubble_c, stall_c, flush_if_c, flush_id_c;
    logic               flush_req_c, load_use_c;
    logic [REG_W-1:0]   id_dest;
    idex_tag_t          id_tag, idex;
    stage_tag_t         exmem, memwb;
    logic               unused_stage_load;

    // Decode the ID instruction into the tag it will carry into EX.
    assign id_dest = dest_of(hz.id_op, hz.id_rt, hz.id_rd);

    always_comb begin
        id_tag = '0;
        if (hz.id_valid) begin
            id_tag.valid   = 1'b1;
            id_tag.we      = (id_dest != '0);
            id_tag.wreg    = id_dest;
            id_tag.is_load = is_load(hz.id_op);
            id_tag.rs      = hz.id_rs;
            id_tag.rt      = hz.id_rt;
            id_tag.op      = hz.id_op;
        end
    end

    dest_tracker u_tracker (
        .clk    (clk),
        .rst    (rst),
        .hold   (hold_c),
        .bubble (bubble_c),
        .id_tag (id_tag),
        .idex   (idex),
        .exmem  (exmem),
        .memwb  (memwb)
    );

    // Only the EX tag's load bit matters for hazards.
    assign unused_stage_load = exmem.is_load ^ memwb.is_load;

    // Behaviour while frozen is decided by the state we froze from.
    assign eff_state   = (state == FREEZE) ? saved : state;
    assign flush_req_c = hz.br_taken || (idex.valid && (idex.op == OP_JAL));
    assign load_use_c  = hz.id_valid && idex.is_load && idex.we &&
                         ((idex.wreg == hz.id_rs) || (idex.wreg == hz.id_rt));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            saved <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            saved <= saved_n;
            cnt   <= cnt_n;
        end
    end

    // Next state and stall/flush controls; priority freeze > flush > load-use.
    always_comb begin
        state_n    = state;
        saved_n    = saved;
        cnt_n      = cnt;
        hold_c     = 1'b0;
        bubble_c   = 1'b0;
        stall_c    = 1'b0;
        flush_if_c = 1'b0;
        flush_id_c = 1'b0;
        if (!hz.mem_ready) begin
            hold_c  = 1'b1;
            stall_c = 1'b1;
            state_n = FREEZE;
            if (state != FREEZE) saved_n = state;
        end else if (flush_req_c) begin
            // Squashes any stalled consumer, so a pending load-use stall is dropped.
            bubble_c   = 1'b1;
            flush_if_c = 1'b1;
            flush_id_c = 1'b1;
            cnt_n      = '0;
            state_n    = RUN;
        end else if (eff_state == LSTALL) begin
            bubble_c   = 1'b1;
            stall_c    = 1'b1;
            flush_id_c = 1'b1;
            cnt_n      = cnt - CNT_W'(1);
            state_n    = (cnt_n == '0) ? RUN : LSTALL;
        end else if (load_use_c) begin
            // The detection cycle is the first of the LOAD_LAT stall cycles.
            bubble_c   = 1'b1;
            stall_c    = 1'b1;
            flush_id_c = 1'b1;
            cnt_n      = CNT_W'(LOAD_LAT - 1);
            state_n    = (LOAD_LAT > 1) ? LSTALL : RUN;
        end else begin
            state_n = RUN;
        end
    end

    // Forward select: EX/MEM wins over MEM/WB; r0 never forwards.
    function automatic fwd_sel_t fwd_for(input logic [REG_W-1:0] src,
                                         input stage_tag_t       em,
                                         input stage_tag_t       mw);
        fwd_sel_t f;
        f = FWD_RF;
        if (src != '0) begin
            if (em.we && (em.wreg == src))      f = FWD_EXMEM;
            else if (mw.we && (mw.wreg == src)) f = FWD_MEMWB;
        end
        return f;
    endfunction

    assign hz.fwd_s    = fwd_for(idex.rs, exmem, memwb);
    assign hz.fwd_t    = fwd_for(idex.rt, exmem, memwb);
    assign hz.stall_if = stall_c;
    assign hz.flush_if = flush_if_c;
    assign hz.flush_id = flush_id_c;

endmodule
